// File: rtl/neuronunit_seq_if.sv
// rtl/neuronunit_seq_if.sv - sample-in / result-out handshake bundle for neuronunit_seq
interface neuronunit_seq_if #(
  parameter int DW = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 s_renew;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [DW-1:0] m_dist;
  logic signed [DW-1:0] m_norm_dist;

  modport master (
    output s_valid, s_data, s_renew, m_ready,
    input  s_ready, m_valid, m_dist, m_norm_dist
  );

  modport slave (
    input  s_valid, s_data, s_renew, m_ready,
    output s_ready, m_valid, m_dist, m_norm_dist
  );
endinterface

// File: rtl/neuronunit_seq.sv
// rtl/neuronunit_seq.sv - INIT/load/renew/divide sequencer for one neuronunit
// Optional divide timeout: NEURONUNIT_SEQ_TIMEOUT_EN
module neuronunit_seq #(
  parameter int DW         = 16,
  parameter int MU_INI     = 8192,
  parameter int SIGMA2_INI = 16384,
  parameter int DIV_TMO    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  neuronunit_seq_if.slave      io,
  input  logic                 reinit,
  output logic signed [DW-1:0] nu_in,
  output logic signed [DW-1:0] nu_mu_ini,
  output logic signed [DW-1:0] nu_sigma2_ini,
  output logic                 nu_ini_para,
  output logic                 nu_en_input,
  output logic                 nu_en_renew,
  output logic                 nu_en_divide,
  output logic                 nu_renew_flag,
  input  logic signed [DW-1:0] nu_dist,
  input  logic signed [DW-1:0] nu_norm_dist,
  input  logic                 nu_div_flag,
  output logic                 err_tmo
);
  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_WAIT_IN  = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_RENEW    = 3'd3;
  localparam logic [2:0] S_DIVIDE   = 3'd4;
  localparam logic [2:0] S_WAIT_DIV = 3'd5;
  localparam logic [2:0] S_OUT      = 3'd6;

  localparam logic signed [DW-1:0] MU_V     = DW'(MU_INI);
  localparam logic signed [DW-1:0] SIGMA2_V = DW'(SIGMA2_INI);

  logic [2:0]           st, nxt;
  logic [1:0]           init_cnt;
  logic                 div_arm;
  logic                 div_done;
  logic                 tmo_hit;
  logic                 ready_q, valid_q;
  logic signed [DW-1:0] dist_q, norm_q;

  // Outputs are registered from the next state, so a held reset keeps every output at 0.
  assign div_done         = (st == S_WAIT_DIV) && div_arm && nu_div_flag;
  assign io.s_ready       = ready_q && !reinit;
  assign io.m_valid       = valid_q;
  assign io.m_dist        = dist_q;
  assign io.m_norm_dist   = norm_q;
  assign nu_mu_ini        = nu_ini_para ? MU_V : '0;
  assign nu_sigma2_ini    = nu_ini_para ? SIGMA2_V : '0;

  always_comb begin
    nxt = st;
    case (st)
      S_INIT:     if (init_cnt == 2'd2) nxt = S_WAIT_IN;
      S_WAIT_IN:  if (reinit) nxt = S_INIT;
                  else if (io.s_valid) nxt = S_LOAD;
      S_LOAD:     nxt = S_RENEW;
      S_RENEW:    nxt = S_DIVIDE;
      S_DIVIDE:   nxt = S_WAIT_DIV;
      S_WAIT_DIV: if (div_done || tmo_hit) nxt = S_OUT;
      S_OUT:      if (io.m_ready) nxt = S_WAIT_IN;
      default:    nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st            <= S_INIT;
      init_cnt      <= 2'd0;
      div_arm       <= 1'b0;
      ready_q       <= 1'b0;
      valid_q       <= 1'b0;
      dist_q        <= '0;
      norm_q        <= '0;
      nu_in         <= '0;
      nu_renew_flag <= 1'b0;
      nu_ini_para   <= 1'b0;
      nu_en_input   <= 1'b0;
      nu_en_renew   <= 1'b0;
      nu_en_divide  <= 1'b0;
    end else begin
      st           <= nxt;
      // init_cnt counts ini_para cycles already issued in this INIT visit.
      init_cnt     <= (nxt != S_INIT) ? 2'd0 : (st == S_INIT) ? init_cnt + 2'd1 : 2'd1;
      div_arm      <= (st == S_WAIT_DIV);
      ready_q      <= (nxt == S_WAIT_IN);
      valid_q      <= (nxt == S_OUT);
      nu_ini_para  <= (nxt == S_INIT);
      nu_en_input  <= (nxt == S_LOAD);
      nu_en_renew  <= (nxt == S_RENEW);
      nu_en_divide <= (nxt == S_DIVIDE);
      if (st == S_WAIT_IN && nxt == S_LOAD) begin
        nu_in         <= io.s_data;
        nu_renew_flag <= io.s_renew;
      end else if (st == S_OUT && nxt == S_WAIT_IN) begin
        nu_in         <= '0;
        nu_renew_flag <= 1'b0;
      end
      if (div_done) begin
        dist_q <= nu_dist;
        norm_q <= nu_norm_dist;
      end else if (tmo_hit) begin
        dist_q <= nu_dist;
        norm_q <= '0;
      end
    end
  end

`ifdef NEURONUNIT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(DIV_TMO + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // tmo_cnt holds the number of WAIT_DIV cycles already completed in this visit.
  assign tmo_hit = (st == S_WAIT_DIV) && !div_done && (tmo_cnt == TW'(DIV_TMO - 1));
  assign err_tmo = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (st == S_WAIT_DIV && nxt == S_WAIT_DIV) ? tmo_cnt + TW'(1) : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^DIV_TMO;
  assign tmo_hit    = 1'b0;
  assign err_tmo    = 1'b0;
`endif
endmodule

// File: tb/tb_neuronunit_seq.sv
// tb/tb_neuronunit_seq.sv - randomized self-checking bench for neuronunit_seq
module tb_neuronunit_seq;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reinit = 1'b0;
  logic signed [DW-1:0] nu_in, nu_mu_ini, nu_sigma2_ini;
  logic nu_ini_para, nu_en_input, nu_en_renew, nu_en_divide, nu_renew_flag, err_tmo;
  logic signed [DW-1:0] nu_dist = '0;
  logic signed [DW-1:0] nu_norm_dist = '0;
  logic nu_div_flag = 1'b0;

  neuronunit_seq_if #(.DW(DW)) io ();

  neuronunit_seq #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .io(io), .reinit(reinit),
    .nu_in(nu_in), .nu_mu_ini(nu_mu_ini), .nu_sigma2_ini(nu_sigma2_ini),
    .nu_ini_para(nu_ini_para), .nu_en_input(nu_en_input), .nu_en_renew(nu_en_renew),
    .nu_en_divide(nu_en_divide), .nu_renew_flag(nu_renew_flag),
    .nu_dist(nu_dist), .nu_norm_dist(nu_norm_dist), .nu_div_flag(nu_div_flag),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_multi = 0;

  logic [5*DW+7:0] all_outs;
  assign all_outs = {io.s_ready, io.m_valid, io.m_dist, io.m_norm_dist, nu_in, nu_mu_ini,
                     nu_sigma2_ini, nu_ini_para, nu_en_input, nu_en_renew, nu_en_divide,
                     nu_renew_flag, err_tmo};

  always @(negedge clk)
    if ($countones({nu_ini_para, nu_en_input, nu_en_renew, nu_en_divide}) > 1) n_multi++;

  typedef struct {
    logic signed [DW-1:0] data;
    logic                 renew;
    int                   dly;
    logic signed [DW-1:0] dv;
    logic signed [DW-1:0] nv;
    int                   lat;
  } exp_t;

  // Observations of the last transaction driven by send().
  int r_tin, r_trn, r_tdv, r_nin, r_nrn, r_ndv, r_lat;
  int r_in_bad, r_unstable, r_busy_rdy, r_timeout;
  logic signed [DW-1:0] r_in, r_d, r_n;
  logic r_rn, r_after_valid, r_after_ready;

  task automatic wait_ready(output int ok);
    int lim = 0;
    @(negedge clk);
    while (!io.s_ready && lim < 50) begin @(negedge clk); lim++; end
    ok = (lim < 50);
  endtask

  // Plays upstream, neuronunit and downstream for one sample; the divider answers
  // from cycle 4+dly, m_ready is held low for `hold` cycles once m_valid shows.
  task automatic send(input logic signed [DW-1:0] data, input logic renew, input int dly,
                      input int hold, input logic signed [DW-1:0] dv, input logic signed [DW-1:0] nv);
    int ok, k;
    logic got;
    r_tin = 0; r_trn = 0; r_tdv = 0; r_nin = 0; r_nrn = 0; r_ndv = 0; r_lat = 0;
    r_in_bad = 0; r_unstable = 0; r_busy_rdy = 0; r_timeout = 0;
    r_in = '0; r_rn = 1'b0; r_d = '0; r_n = '0; r_after_valid = 1'b1; r_after_ready = 1'b0;
    io.m_ready = 1'b0;
    wait_ready(ok);
    if (ok == 0) begin r_timeout = 1; return; end
    io.s_valid = 1'b1; io.s_data = data; io.s_renew = renew;
    got = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      io.s_valid = 1'b0; io.s_data = DW'($urandom); io.s_renew = 1'($urandom);
      if (nu_en_input)  begin r_nin++; r_tin = k; r_in = nu_in; end
      if (nu_en_renew)  begin r_nrn++; r_trn = k; r_rn = nu_renew_flag; end
      if (nu_en_divide) begin r_ndv++; r_tdv = k; end
      if (nu_in !== data || nu_renew_flag !== renew) r_in_bad++;
      if (io.s_ready) r_busy_rdy++;
      if (io.m_valid) begin got = 1'b1; break; end
      if (k >= 4 + dly) begin nu_div_flag = 1'b1; nu_dist = dv; nu_norm_dist = nv; end
      else begin nu_div_flag = 1'b0; nu_dist = DW'($urandom); nu_norm_dist = DW'($urandom); end
    end
    if (!got) begin r_timeout = 1; nu_div_flag = 1'b0; return; end
    r_lat = k; r_d = io.m_dist; r_n = io.m_norm_dist;
    nu_div_flag = 1'b0; nu_dist = DW'($urandom); nu_norm_dist = DW'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (io.m_valid !== 1'b1 || io.m_dist !== r_d || io.m_norm_dist !== r_n ||
          nu_in !== data || nu_renew_flag !== renew) r_unstable++;
      if (io.s_ready) r_busy_rdy++;
    end
    io.m_ready = 1'b1;
    @(negedge clk);
    r_after_valid = io.m_valid; r_after_ready = io.s_ready;
    io.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0, n_ini = 0, t_rdy = 0, mu_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (all_outs !== '0) bad++;
      io.s_valid = 1'($urandom); io.s_data = DW'($urandom); reinit = 1'($urandom);
      nu_div_flag = 1'($urandom); io.m_ready = 1'($urandom);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_outs got=%0d nonzero cycles exp=0", bad); end
    io.s_valid = 1'b0; reinit = 1'b0; nu_div_flag = 1'b0; io.m_ready = 1'b0;
    rst = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (nu_ini_para) n_ini++;
      if (nu_ini_para && (nu_mu_ini !== 16'sd8192 || nu_sigma2_ini !== 16'sd16384)) mu_bad++;
      if (!nu_ini_para && (nu_mu_ini !== '0 || nu_sigma2_ini !== '0)) mu_bad++;
      if (nu_ini_para && j > 2) mu_bad++;
      if (io.s_ready && t_rdy == 0) t_rdy = j;
      if (t_rdy != 0 && !io.s_ready) mu_bad++;
    end
    checks++; if (n_ini != 2) begin failures++; $display("FAIL init_len got=%0d exp=2", n_ini); end
    checks++; if (t_rdy != 3) begin failures++; $display("FAIL init_ready got=%0d exp=3", t_rdy); end
    checks++; if (mu_bad != 0) begin failures++; $display("FAIL init_values got=%0d bad exp=0", mu_bad); end
  endtask

  task automatic test_samples();
    exp_t q[$];
    exp_t e;
    int m0 = n_multi;
    for (int i = 0; i < 9; i++) begin
      e.data  = (i < 2) ? 16'sd0 : (i == 2) ? 16'sd3277 : DW'($urandom);
      e.renew = (i == 0 || i == 2) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
      e.dly   = (i == 0) ? 0 : int'($urandom_range(0, 6));
      e.dv    = DW'($urandom);
      e.nv    = DW'($urandom);
      e.lat   = (e.dly + 5 > 6) ? e.dly + 5 : 6;
      q.push_back(e);
    end
    for (int i = 0; q.size() > 0; i++) begin
      e = q.pop_front();
      send(e.data, e.renew, e.dly, 0, e.dv, e.nv);
      checks++; if (r_timeout != 0) begin failures++; $display("FAIL s%0d timeout got=%0d exp=0", i, r_timeout); end
      checks++; if (!(r_tin == 1 && r_trn == 2 && r_tdv == 3)) begin failures++;
        $display("FAIL s%0d strobe_time got=%0d/%0d/%0d exp=1/2/3", i, r_tin, r_trn, r_tdv); end
      checks++; if (!(r_nin == 1 && r_nrn == 1 && r_ndv == 1)) begin failures++;
        $display("FAIL s%0d strobe_count got=%0d/%0d/%0d exp=1/1/1", i, r_nin, r_nrn, r_ndv); end
      checks++; if (r_in !== e.data) begin failures++; $display("FAIL s%0d nu_in got=%0d exp=%0d", i, r_in, e.data); end
      checks++; if (r_rn !== e.renew) begin failures++; $display("FAIL s%0d renew got=%0b exp=%0b", i, r_rn, e.renew); end
      checks++; if (r_in_bad != 0) begin failures++; $display("FAIL s%0d in_held got=%0d exp=0", i, r_in_bad); end
      checks++; if (r_lat != e.lat) begin failures++; $display("FAIL s%0d latency got=%0d exp=%0d", i, r_lat, e.lat); end
      checks++; if (r_d !== e.dv) begin failures++; $display("FAIL s%0d dist got=%0d exp=%0d", i, r_d, e.dv); end
      checks++; if (r_n !== e.nv) begin failures++; $display("FAIL s%0d norm got=%0d exp=%0d", i, r_n, e.nv); end
      checks++; if (r_busy_rdy != 0) begin failures++; $display("FAIL s%0d busy_ready got=%0d exp=0", i, r_busy_rdy); end
      checks++; if (r_after_valid !== 1'b0 || r_after_ready !== 1'b1) begin failures++;
        $display("FAIL s%0d drain got=v%0b/r%0b exp=v0/r1", i, r_after_valid, r_after_ready); end
    end
    checks++; if (n_multi != m0) begin failures++; $display("FAIL one_strobe got=%0d overlaps exp=0", n_multi - m0); end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] dv = DW'($urandom), nv = DW'($urandom), d = DW'($urandom);
    int dly = int'($urandom_range(0, 3));
    send(d, 1'b1, dly, 10, dv, nv);
    checks++; if (r_d !== dv || r_n !== nv) begin failures++; $display("FAIL bp_data got=%0d/%0d exp=%0d/%0d", r_d, r_n, dv, nv); end
    checks++; if (r_unstable != 0) begin failures++; $display("FAIL bp_hold got=%0d unstable exp=0", r_unstable); end
    checks++; if (r_busy_rdy != 0) begin failures++; $display("FAIL bp_sready got=%0d exp=0", r_busy_rdy); end
    checks++; if (r_after_valid !== 1'b0 || r_after_ready !== 1'b1) begin failures++;
      $display("FAIL bp_drain got=v%0b/r%0b exp=v0/r1", r_after_valid, r_after_ready); end
  endtask

  task automatic test_reinit();
    logic signed [DW-1:0] data = DW'($urandom), dv = DW'($urandom), nv = DW'($urandom);
    logic signed [DW-1:0] gd = '0, gn = '0, seen_in = '0;
    int ok, n_ini = 0, t_rdy = 0, t_in = 0, t_val = 0;
    wait_ready(ok);
    reinit = 1'b1; io.s_valid = 1'b1; io.s_data = data; io.s_renew = 1'b1;
    #1;
    checks++; if (io.s_ready !== 1'b0 || ok == 0) begin failures++; $display("FAIL reinit_sready got=%0b exp=0", io.s_ready); end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      reinit = 1'b0;
      if (nu_ini_para) n_ini++;
      if (io.s_ready && t_rdy == 0) t_rdy = k;
      if (nu_en_input && t_in == 0) begin t_in = k; seen_in = nu_in; end
      if (t_in != 0) io.s_valid = 1'b0;
      if (io.m_valid) begin t_val = k; gd = io.m_dist; gn = io.m_norm_dist; break; end
      nu_div_flag = (k >= 8); nu_dist = dv; nu_norm_dist = nv;
    end
    nu_div_flag = 1'b0; io.s_valid = 1'b0; io.m_ready = 1'b1;
    @(negedge clk);
    io.m_ready = 1'b0;
    checks++; if (n_ini != 2) begin failures++; $display("FAIL reinit_len got=%0d exp=2", n_ini); end
    checks++; if (t_rdy != 3) begin failures++; $display("FAIL reinit_ready got=%0d exp=3", t_rdy); end
    checks++; if (t_in != 4 || seen_in !== data) begin failures++;
      $display("FAIL reinit_accept got=t%0d/%0d exp=t4/%0d", t_in, seen_in, data); end
    checks++; if (t_val != 9 || gd !== dv || gn !== nv) begin failures++;
      $display("FAIL reinit_result got=t%0d/%0d/%0d exp=t9/%0d/%0d", t_val, gd, gn, dv, nv); end
  endtask

  task automatic test_abort();
    int ok, n_ini = 0, t_rdy = 0, n_val = 0;
    wait_ready(ok);
    io.s_valid = 1'b1; io.s_data = DW'($urandom); io.s_renew = 1'b1; io.m_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin @(negedge clk); io.s_valid = 1'b0; end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (all_outs !== '0 || ok == 0) begin failures++; $display("FAIL abort_outs got=%h exp=0", all_outs); end
    nu_div_flag = 1'b1; rst = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (nu_ini_para) n_ini++;
      if (io.s_ready && t_rdy == 0) t_rdy = j;
      if (io.m_valid) n_val++;
    end
    nu_div_flag = 1'b0; io.m_ready = 1'b0;
    checks++; if (n_val != 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", n_val); end
    checks++; if (n_ini != 2 || t_rdy != 3) begin failures++;
      $display("FAIL abort_reinit got=ini%0d/rdy%0d exp=ini2/rdy3", n_ini, t_rdy); end
  endtask

  task automatic test_timeout();
    logic signed [DW-1:0] dv = DW'($urandom);
    logic signed [DW-1:0] gd = '0, gn = '1;
    logic err_pre = 1'b1, err_val = 1'b0;
    int ok, t_val = 0;
    wait_ready(ok);
    io.s_valid = 1'b1; io.s_data = DW'($urandom); io.s_renew = 1'b0;
    nu_div_flag = 1'b0; nu_dist = dv; nu_norm_dist = 16'sh1234;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      io.s_valid = 1'b0;
      if (k == 35) err_pre = err_tmo;
      if (io.m_valid) begin t_val = k; gd = io.m_dist; gn = io.m_norm_dist; err_val = err_tmo; break; end
    end
`ifdef NEURONUNIT_SEQ_TIMEOUT_EN
    checks++; if (t_val != 36 || ok == 0) begin failures++; $display("FAIL tmo_time got=%0d exp=36", t_val); end
    checks++; if (err_pre !== 1'b0 || err_val !== 1'b1) begin failures++;
      $display("FAIL tmo_err got=pre%0b/at%0b exp=pre0/at1", err_pre, err_val); end
    checks++; if (gd !== dv || gn !== '0) begin failures++; $display("FAIL tmo_data got=%0d/%0d exp=%0d/0", gd, gn, dv); end
    io.m_ready = 1'b1;
    @(negedge clk);
    io.m_ready = 1'b0;
    checks++; if (err_tmo !== 1'b1 || io.s_ready !== 1'b1) begin failures++;
      $display("FAIL tmo_sticky got=err%0b/rdy%0b exp=err1/rdy1", err_tmo, io.s_ready); end
`else
    checks++; if (t_val != 0 || ok == 0) begin failures++; $display("FAIL notmo_result got=%0d exp=0", t_val); end
    checks++; if (err_pre !== 1'b0 || err_tmo !== 1'b0) begin failures++;
      $display("FAIL notmo_err got=%0b/%0b exp=0/0", err_pre, err_tmo); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_ready(ok);
    checks++; if (ok == 0) begin failures++; $display("FAIL notmo_recover got=%0d exp=1", ok); end
`endif
  endtask

  initial begin
    io.s_valid = 1'b0; io.s_data = '0; io.s_renew = 1'b0; io.m_ready = 1'b0;
    test_reset();
    test_samples();
    test_backpressure();
    test_reinit();
    test_abort();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
